// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// The M-bundle index constants let the datapath slice ctlm consistently.
package pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int BR = 2;
   localparam int MR = 1;
   localparam int MW = 0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clear) begin
         q <= '0;
      end else if (inc && (q != {CNT_W{1'b1}})) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Load/flush/PC sequencing for the 5-stage pipeline: memory-wait freeze,
// taken-branch squash and load-use stall, in that priority order.
module pipe_hazard_ctl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic             exmem_branch,
   input  logic             exmem_zero,
   input  logic             exmem_memread,
   input  logic             exmem_memwrite,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             pc_src,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_bubble,
   output logic             mem_req,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             dbg_state
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       memop, in_wait, abort, freeze, taken, load_use;

   // Handshake: mem_req stays high for as long as EX/MEM holds a memory op;
   // the access completes in the cycle mem_ready is seen high with mem_req.
   assign memop    = exmem_memread | exmem_memwrite;
   assign in_wait  = (state == MEM_WAIT);
   assign abort    = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);
   assign freeze   = (in_wait || memop) && !mem_ready && !abort;
   assign taken    = exmem_branch && exmem_zero && !freeze;
   assign load_use = idex_memread && (idex_rt != REG_ZERO) &&
                     ((idex_rt == ifid_rs) || (idex_rt == ifid_rt)) &&
                     !freeze && !taken;
   assign mem_req  = memop && !rst;
   assign dbg_state = state;

   always_comb begin
      pc_en        = 1'b1;
      pc_src       = 1'b0;
      ifid_en      = 1'b1;
      idex_en      = 1'b1;
      exmem_en     = 1'b1;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_flush  = 1'b0;
      memwb_bubble = 1'b0;
      if (rst) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         ifid_flush   = 1'b1;
         idex_flush   = 1'b1;
         exmem_flush  = 1'b1;
         memwb_bubble = 1'b1;
      end else if (freeze) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else begin
         // An aborted access must not write back garbage.
         if (abort) memwb_bubble = 1'b1;
         if (taken) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (memop && !mem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (mem_ready || abort) begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
                  if (!mem_ready) mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= 8'd0;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (!pc_en),
      .q     (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (taken && !rst),
      .q     (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl with a short timeout and narrow
// counters so that abort and saturation are reached quickly.
module tb_pipe_hazard_ctl;

   localparam int TMO = 4;
   localparam int CW  = 3;

   // ctl = {pc_en, pc_src, ifid_en, idex_en, exmem_en,
   //        ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_req}
   localparam logic [9:0] C_DEF = 10'b1_0_111_000_0_0;
   localparam logic [9:0] C_REQ = 10'b1_0_111_000_0_1;
   localparam logic [9:0] C_RST = 10'b0_0_000_111_1_0;
   localparam logic [9:0] C_FRZ = 10'b0_0_000_000_1_1;
   localparam logic [9:0] C_ABT = 10'b1_0_111_000_1_1;
   localparam logic [9:0] C_LU  = 10'b0_0_011_010_0_0;
   localparam logic [9:0] C_BR  = 10'b1_1_111_111_0_0;

   logic          clk, rst;
   logic [4:0]    ifid_rs, ifid_rt, idex_rt;
   logic          idex_memread, exmem_branch, exmem_zero;
   logic          exmem_memread, exmem_memwrite, mem_ready;
   logic          pc_en, pc_src, ifid_en, idex_en, exmem_en;
   logic          ifid_flush, idex_flush, exmem_flush, memwb_bubble;
   logic          mem_req, mem_err, dbg_state;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic [9:0]    ctl;

   int n_vec = 0;
   int n_bad = 0;
   logic [9:0] exp_q[$];

   assign ctl = {pc_en, pc_src, ifid_en, idex_en, exmem_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_req};

   pipe_hazard_ctl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .ifid_rs        (ifid_rs),
      .ifid_rt        (ifid_rt),
      .idex_memread   (idex_memread),
      .idex_rt        (idex_rt),
      .exmem_branch   (exmem_branch),
      .exmem_zero     (exmem_zero),
      .exmem_memread  (exmem_memread),
      .exmem_memwrite (exmem_memwrite),
      .mem_ready      (mem_ready),
      .pc_en          (pc_en),
      .pc_src         (pc_src),
      .ifid_en        (ifid_en),
      .idex_en        (idex_en),
      .exmem_en       (exmem_en),
      .ifid_flush     (ifid_flush),
      .idex_flush     (idex_flush),
      .exmem_flush    (exmem_flush),
      .memwb_bubble   (memwb_bubble),
      .mem_req        (mem_req),
      .mem_err        (mem_err),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_in(input logic lu_mr, input logic [4:0] lu_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic zr,
                         input logic mr, input logic mw, input logic rdy);
      idex_memread   = lu_mr;
      idex_rt        = lu_rt;
      ifid_rs        = rs;
      ifid_rt        = rt;
      exmem_branch   = br;
      exmem_zero     = zr;
      exmem_memread  = mr;
      exmem_memwrite = mw;
      mem_ready      = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_regs(input string tag, input logic st, input int stalls,
                           input int flushes, input logic err);
      chk({tag, "_state"}, 32'(dbg_state), 32'(st));
      chk({tag, "_stall"}, 32'(stall_cnt), 32'(stalls));
      chk({tag, "_flush"}, 32'(flush_cnt), 32'(flushes));
      chk({tag, "_err"},   32'(mem_err),   32'(err));
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("rst_ctl", 32'(ctl), 32'(C_RST));
      tick();
      chk_regs("rst", 1'b0, 0, 0, 1'b0);

      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("idle_ctl", 32'(ctl), 32'(C_DEF));
      tick();

      // load-use on rs, then the bubble clears it
      set_in(1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, 1);
      chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
      tick();
      chk("lu_rs_stall", 32'(stall_cnt), 32'd1);
      set_in(0, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0, 1);
      chk("lu_bub_ctl", 32'(ctl), 32'(C_DEF));
      tick();
      chk("lu_bub_stall", 32'(stall_cnt), 32'd1);

      set_in(1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0, 1);
      chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
      tick();
      chk("lu_rt_stall", 32'(stall_cnt), 32'd2);

      set_in(1, 5'd0, 5'd5, 5'd0, 0, 0, 0, 0, 1);
      chk("lu_r0_ctl", 32'(ctl), 32'(C_DEF));
      tick();
      chk("lu_r0_stall", 32'(stall_cnt), 32'd2);

      // taken branch beats load-use
      set_in(1, 5'd8, 5'd8, 5'd0, 1, 1, 0, 0, 1);
      chk("br_ctl", 32'(ctl), 32'(C_BR));
      tick();
      chk_regs("br", 1'b0, 2, 1, 1'b0);
      set_in(0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 1);
      chk("br_nt_ctl", 32'(ctl), 32'(C_DEF));
      tick();
      chk("br_nt_flush", 32'(flush_cnt), 32'd1);

      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("mem1_ctl", 32'(ctl), 32'(C_REQ));
      tick();
      chk("mem1_state", 32'(dbg_state), 32'd0);

      // three wait cycles, release on the fourth
      exp_q.push_back(C_FRZ);
      exp_q.push_back(C_FRZ);
      exp_q.push_back(C_FRZ);
      exp_q.push_back(C_REQ);
      for (int i = 0; i < 4; i++) begin
         logic [9:0] e;
         set_in(0, 0, 0, 0, 0, 0, 1, 0, (i == 3));
         e = exp_q.pop_front();
         chk($sformatf("wait%0d_ctl", i), 32'(ctl), 32'(e));
         tick();
         chk($sformatf("wait%0d_state", i), 32'(dbg_state), (i < 3) ? 32'd1 : 32'd0);
      end
      chk_regs("wait", 1'b0, 5, 1, 1'b0);

      // timeout: 3 freeze cycles then abort; stall count saturates at 7
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
         chk($sformatf("tmo%0d_ctl", i), 32'(ctl), (i < 3) ? 32'(C_FRZ) : 32'(C_ABT));
         tick();
      end
      chk_regs("tmo", 1'b0, 7, 1, 1'b1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("post_tmo_ctl", 32'(ctl), 32'(C_DEF));
      tick();
      chk_regs("sticky", 1'b0, 7, 1, 1'b1);

      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst2_ctl", 32'(ctl), 32'(C_RST));
      tick();
      chk_regs("rst2", 1'b0, 0, 0, 1'b0);

      // reset while waiting drops the request at once
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("rmw_frz_ctl", 32'(ctl), 32'(C_FRZ));
      tick();
      chk("rmw_state", 32'(dbg_state), 32'd1);
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("rmw_rst_ctl", 32'(ctl), 32'(C_RST));
      tick();
      chk_regs("rmw", 1'b0, 0, 0, 1'b0);
      rst = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("rmw_idle_ctl", 32'(ctl), 32'(C_DEF));
      tick();
      chk("rmw_idle_stall", 32'(stall_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
- Sequencing controller for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Per cycle it decides which registers load, which are flushed to bubbles, and when the PC redirects.
- Handles three cases: load-use hazards, taken branches resolved at EX/MEM, and multi-cycle data-memory accesses via a req/ready handshake with timeout.
- Sits beside the datapath; its enables/flushes drive every pipeline register and the PC.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MEM_WAIT before abort (legal range 2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifid_rs  in  5  rs field of instruction in IF/ID
- ifid_rt  in  5  rt field of instruction in IF/ID
- idex_memread  in  1  ID/EX M-control memread
- idex_rt  in  5  destination rt of instruction in ID/EX
- exmem_branch  in  1  EX/MEM branch control bit
- exmem_zero  in  1  EX/MEM ALU zero flag
- exmem_memread  in  1  EX/MEM memread
- exmem_memwrite  in  1  EX/MEM memwrite
- mem_ready  in  1  data memory done (sampled each cycle)
- pc_en  out  1  PC load enable
- pc_src  out  1  1 = PC loads branch target (EX/MEM add_result)
- ifid_en, idex_en, exmem_en  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load zeros (bubble) this cycle
- memwb_bubble  out  1  MEM/WB loads bubble (write-back controls = 0)
- mem_req  out  1  data memory request
- mem_err  out  1  sticky, memory timeout occurred
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=RUN; wait_cnt=0; mem_err=0; stall_cnt=flush_cnt=0.
  - While rst=1, outputs are forced: all *_en=0, all *_flush=1, memwb_bubble=1, pc_src=0, mem_req=0.
  - Reset mid-MEM_WAIT drops mem_req the same cycle. No abort is reported.
- Outputs are combinational from state plus current inputs; state and counters are registered.
- Default (RUN, no event): all enables=1, flushes=0, pc_src=0, memwb_bubble=0.
- Signals: memop = exmem_memread | exmem_memwrite; mem_req = memop in RUN and MEM_WAIT.
- Priority, highest first: memory wait, taken branch, load-use.
- Memory wait:
  - RUN with memop=1 and mem_ready=0: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1; next state MEM_WAIT, wait_cnt=1.
  - RUN with memop=1 and mem_ready=1: no stall (single-cycle access).
  - MEM_WAIT with mem_ready=0: same freeze, wait_cnt+1.
  - MEM_WAIT with mem_ready=1: default outputs this cycle (result captured into MEM/WB); next state RUN.
  - MEM_WAIT with wait_cnt==MEM_TIMEOUT-1 and mem_ready=0: abort. Freeze released this cycle, memwb_bubble=1, mem_err set; next state RUN.
  - Branch and load-use conditions are ignored while frozen. They are re-evaluated on the release cycle.
- Taken branch: exmem_branch & exmem_zero, not frozen.
  - pc_src=1, pc_en=1.
  - ifid_flush=idex_flush=exmem_flush=1 (three younger instructions squashed).
  - flush_cnt+1.
  - Load-use is suppressed that cycle.
- Load-use: idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt), not frozen, no taken branch.
  - pc_en=0, ifid_en=0, idex_flush=1; exactly one cycle.
  - The bubble clears idex_memread, so there is no re-detection.
- Release cycle with a simultaneous taken branch: branch is handled normally in that cycle.
- stall_cnt increments every non-reset cycle with pc_en=0. Both counters saturate at all-ones.
- mem_err clears only on rst.

Decomposition:
- Shared package pipe_pkg:
  - state enum {RUN, MEM_WAIT}, 1 bit.
  - Constant REG_ZERO = 5'd0.
  - Control-bit index constants for the M-bundle: BR=2, MR=1, MW=0, so callers slice ctlm consistently.
- Sub-module sat_counter (CNT_W, inc, clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8, mem_ready=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle defaults; stall_cnt=1.
- Load-use on $0: idex_rt=0, ifid_rt=0, idex_memread=1 -> no stall, all enables 1.
- Taken branch: exmem_branch=1, exmem_zero=1 with a load-use condition also present -> pc_src=1, three flushes=1, pc_en=1, flush_cnt=1, no stall. With exmem_zero=0 -> defaults.
- Mem wait: exmem_memread=1, mem_ready low 3 cycles then high -> mem_req=1 for 4 cycles, 3 frozen cycles with memwb_bubble=1, release on 4th; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_ready stuck 0 -> freeze cycles 1-3, abort on cycle 4, mem_err=1 sticky, state RUN; rst pulse clears mem_err.
- Reset mid-wait: rst asserted on 2nd MEM_WAIT cycle -> mem_req=0 and all flushes=1 immediately; after release, state RUN with counters 0.
